// File: rtl/gate_arbiter.sv
// Four requesters share one WIDTH-bit inverter. Grant, then the result is presented one cycle later,
// 3 cycles minimum per transaction; the result holds in RESP until res_ready, and new grants wait for IDLE.
module gate_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [1:0]         res_id,
  output logic [WIDTH-1:0]   res_data,
  output logic               busy,
  output logic [7:0]         svc_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] operand_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic [3:0]       gnt_nxt;
  logic             res_valid_nxt;
  logic [1:0]       res_id_nxt;
  logic [WIDTH-1:0] res_data_nxt;
  logic [7:0]       svc_cnt_nxt;
  logic [WIDTH-1:0] inv_out;

  logic [WIDTH-1:0] slice [4];
  logic [1:0]       win;
  logic             win_found;
  logic [1:0]       cand;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    assign slice[i] = din[i*WIDTH +: WIDTH];
  end

  // The single shared datapath element.
  assign inv_out = ~operand;
  assign busy    = (state != IDLE);

  // Round-robin: first requester found scanning upward from the one after the last winner.
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    cand      = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_found && req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = 4'b0000;
    res_valid_nxt = res_valid;
    res_id_nxt    = res_id;
    res_data_nxt  = res_data;
    operand_nxt   = operand;
    ptr_nxt       = ptr;
    svc_cnt_nxt   = svc_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt     = 4'b0001 << win;
          operand_nxt = slice[win];
          res_id_nxt  = win;
          ptr_nxt     = win;
          state_nxt   = EXEC;
        end
      end
      EXEC: begin
        res_data_nxt  = inv_out;
        res_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          svc_cnt_nxt   = svc_cnt + 8'd1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ptr resets to 3 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      res_valid <= 1'b0;
      res_id    <= 2'd0;
      res_data  <= '0;
      operand   <= '0;
      ptr       <= 2'd3;
      svc_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      res_valid <= res_valid_nxt;
      res_id    <= res_id_nxt;
      res_data  <= res_data_nxt;
      operand   <= operand_nxt;
      ptr       <= ptr_nxt;
      svc_cnt   <= svc_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// Randomized bench for gate_arbiter: a transaction-level model queues per-cycle and per-result
// expectations as stimulus is issued; an independent monitor pops and compares them.
module tb_gate_arbiter;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [3:0]     gnt;
  logic           res_valid;
  logic           res_ready;
  logic [1:0]     res_id;
  logic [W-1:0]   res_data;
  logic           busy;
  logic [7:0]     svc_cnt;

  gate_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy),
    .svc_cnt   (svc_cnt)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic       busy;
    logic [7:0] svc;
  } cyc_t;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } txn_t;

  cyc_t   cyc_q[$];
  txn_t   txn_q[$];
  int     obs_grants[$];

  int     n_pass  = 0;
  int     n_total = 0;
  bit     in_rst  = 1'b1;
  bit     prev_vld = 1'b0;
  txn_t   cur;
  logic [W-1:0] last_res_data = '0;
  logic [1:0]   last_res_id   = '0;

  // Reference model: age of the in-flight transaction (-1 none, 0 just granted, 1 result out).
  int         m_age  = -1;
  int         m_last = 3;
  int         m_done = 0;
  logic [3:0] m_grant = 4'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs (at a negedge), predict the following edge, then wait a cycle.
  task automatic drive_cycle(input logic [3:0] r, input logic [4*W-1:0] d, input logic rdy);
    cyc_t e;
    txn_t t;
    int   w;
    req       = r;
    din       = d;
    res_ready = rdy;
    m_grant   = 4'b0;
    if (m_age < 0) begin
      if (r != 4'b0) begin
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
        m_last  = w;
        m_age   = 0;
        m_grant = 4'(1 << w);
        t.id    = 2'(w);
        t.data  = ~d[w*W +: W];
        txn_q.push_back(t);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rdy) begin
      m_age = -1;
      m_done++;
    end
    e.gnt  = m_grant;
    e.vld  = (m_age >= 1);
    e.busy = (m_age >= 0);
    e.svc  = 8'(m_done % 256);
    cyc_q.push_back(e);
    @(negedge clk);
  endtask

  // Starts at a negedge; asserts reset between edges so its effect must be asynchronous.
  task automatic do_reset();
    in_rst = 1'b1;
    cyc_q.delete();
    txn_q.delete();
    #3 rst_n = 1'b0;
    #1;
    check("rst_gnt",       32'(gnt),       32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_svc_cnt",   32'(svc_cnt),   32'd0);
    req       = 4'b0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_age   = -1;
    m_last  = 3;
    m_done  = 0;
    m_grant = 4'b0;
    cyc_q.push_back('0);
    in_rst  = 1'b0;
  endtask

  // Monitor: compares DUT outputs just after each negedge, independent of the stimulus.
  initial begin : mon
    cyc_t e;
    forever begin
      @(negedge clk);
      #1;
      if (in_rst) begin
        prev_vld = 1'b0;
      end else begin
        if (cyc_q.size() == 0) begin
          n_total++;
          $display("FAIL cyc_q: no expectation queued for this cycle");
        end else begin
          e = cyc_q.pop_front();
          check("gnt",       32'(gnt),       32'(e.gnt));
          check("res_valid", 32'(res_valid), 32'(e.vld));
          check("busy",      32'(busy),      32'(e.busy));
          check("svc_cnt",   32'(svc_cnt),   32'(e.svc));
        end
        check("gnt_onehot",   32'($onehot0(gnt)),              32'd1);
        check("gnt_vld_excl", 32'(res_valid && (gnt != 4'b0)), 32'd0);
        for (int i = 0; i < 4; i++) if (gnt[i]) obs_grants.push_back(i);
        if (res_valid && !prev_vld) begin
          if (txn_q.size() == 0) begin
            n_total++;
            $display("FAIL txn_q: result presented with none expected, id %0d data %0h", res_id, res_data);
          end else begin
            cur = txn_q.pop_front();
          end
          last_res_data = res_data;
          last_res_id   = res_id;
        end
        if (res_valid) begin
          check("res_id",   32'(res_id),   32'(cur.id));
          check("res_data", 32'(res_data), 32'(cur.data));
        end
        prev_vld = res_valid;
      end
    end
  end

  initial begin : drv
    logic [3:0]     rv;
    logic [4*W-1:0] dv;
    logic           rdy;
    int             stall;
    int             exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rv    = 4'b0;
    stall = 0;
    rst_n = 1'b0;
    req   = 4'b0;
    din   = '0;
    res_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request: operand A5 must come back as 5A for requester 0.
    dv = 32'($urandom);
    dv[7:0] = 8'hA5;
    drive_cycle(4'b0001, dv, 1'b1);
    for (int c = 0; c < 4; c++) drive_cycle(4'b0000, 32'($urandom), 1'b1);
    check("single_data", 32'(last_res_data), 32'h5A);
    check("single_id",   32'(last_res_id),   32'd0);
    check("single_svc",  32'(svc_cnt),       32'd1);
    check("single_busy", 32'(busy),          32'd0);

    // Random traffic with stalls, long enough for svc_cnt to wrap.
    for (int c = 0; c < 20000 && m_done < 300; c++) begin
      rv = rv & ~m_grant;
      for (int i = 0; i < 4; i++) if (!rv[i] && $urandom_range(0, 3) == 0) rv[i] = 1'b1;
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) stall = $urandom_range(3, 6);
      end
      drive_cycle(rv, 32'($urandom), rdy);
    end
    check("wrap_reached", 32'(m_done >= 300), 32'd1);
    check("wrap_svc",     32'(svc_cnt),       32'(m_done % 256));

    // Run until a result is being presented, then reset mid-RESP.
    for (int c = 0; c < 200 && m_age < 1; c++) begin
      rv = rv & ~m_grant;
      for (int i = 0; i < 4; i++) if (!rv[i] && $urandom_range(0, 1) == 0) rv[i] = 1'b1;
      drive_cycle(rv, 32'($urandom), 1'b0);
    end
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    do_reset();

    // All four requesting continuously: 0,1,2,3,0 and five completions in 15 cycles.
    obs_grants.delete();
    for (int c = 0; c < 15; c++) drive_cycle(4'hF, 32'($urandom), 1'b1);
    check("fair_svc",   32'(svc_cnt),                 32'd5);
    check("fair_count", 32'(obs_grants.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      if (k < obs_grants.size()) check("fair_order", 32'(obs_grants[k]), 32'(exp_order[k]));

    for (int c = 0; c < 4; c++) drive_cycle(4'b0000, 32'($urandom), 1'b1);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
